// File: rtl/booth_seq.sv
// Sequential radix-2 Booth multiplier, 16x16 signed -> 32-bit signed product.
// One 16-bit carry-select adder is shared by every iteration.

// 16-bit carry-select adder: low byte ripples, high byte is precomputed for both carries.
module booth_csa16 (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic        c_in_i,
   output logic [16:0] x_o
);

   logic [8:0] lo_sum;
   logic [8:0] hi_sum0;
   logic [8:0] hi_sum1;

   // Low half and both speculative high halves, then select on the low carry-out.
   always_comb begin
      lo_sum  = {1'b0, a_i[7:0]} + {1'b0, b_i[7:0]} + {8'd0, c_in_i};
      hi_sum0 = {1'b0, a_i[15:8]} + {1'b0, b_i[15:8]};
      hi_sum1 = {1'b0, a_i[15:8]} + {1'b0, b_i[15:8]} + 9'd1;
      x_o     = lo_sum[8] ? {hi_sum1, lo_sum[7:0]} : {hi_sum0, lo_sum[7:0]};
   end

endmodule

module booth_seq (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic [15:0] mcand_i,
   input  logic [15:0] mplier_i,
   input  logic        ack_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] product_o
);

   typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

   state_e      state_q, state_d;
   logic [15:0] acc_q, acc_d;
   logic [15:0] q_q, q_d;
   logic        q_m1_q, q_m1_d;
   logic [15:0] m_q, m_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] product_q, product_d;

   logic [15:0] b_op;
   logic        c_in;
   logic [16:0] x_sum;
   logic        sum_sign;

   // Booth recoding of {Q[0], q_m1}: add M, subtract M (add ~M + 1), or pass ACC through.
   always_comb begin
      b_op = 16'd0;
      c_in = 1'b0;
      unique case ({q_q[0], q_m1_q})
         2'b01: begin
            b_op = m_q;
            c_in = 1'b0;
         end
         2'b10: begin
            b_op = ~m_q;
            c_in = 1'b1;
         end
         default: begin
            b_op = 16'd0;
            c_in = 1'b0;
         end
      endcase
   end

   booth_csa16 u_csa (
      .a_i    (acc_q),
      .b_i    (b_op),
      .c_in_i (c_in),
      .x_o    (x_sum)
   );

   // Sign of the exact 17-bit result; with B=0 and no carry-in this reduces to ACC[15].
   assign sum_sign = acc_q[15] ^ b_op[15] ^ x_sum[16];

   // Next-state: load on accepted start, shift once per iteration, hand off on ack.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      q_d       = q_q;
      q_m1_d    = q_m1_q;
      m_d       = m_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               acc_d   = 16'd0;
               q_d     = mplier_i;
               q_m1_d  = 1'b0;
               m_d     = mcand_i;
               cnt_d   = 4'd0;
               state_d = StIter;
            end
         end
         StIter: begin
            acc_d  = {sum_sign, x_sum[15:1]};
            q_d    = {x_sum[0], q_q[15:1]};
            q_m1_d = q_q[0];
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               product_d = {sum_sign, x_sum[15:1], x_sum[0], q_q[15:1]};
               state_d   = StDone;
            end
         end
         StDone: begin
            if (ack_i) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         acc_q     <= 16'd0;
         q_q       <= 16'd0;
         q_m1_q    <= 1'b0;
         m_q       <= 16'd0;
         cnt_q     <= 4'd0;
         product_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         q_q       <= q_d;
         q_m1_q    <= q_m1_d;
         m_q       <= m_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   // Status outputs decode directly from the state register.
   always_comb begin
      busy_o    = (state_q != StIdle);
      done_o    = (state_q == StDone);
      product_o = product_q;
   end

endmodule

// File: tb/tb_booth_seq.sv
// Directed bench for booth_seq: hand-computed products, protocol and reset behaviour.
module tb_booth_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] mcand;
   logic [15:0] mplier;
   logic        ack;
   logic        busy;
   logic        done;
   logic [31:0] product;

   int checks;
   int errors;

   booth_seq dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .start_i   (start),
      .mcand_i   (mcand),
      .mplier_i  (mplier),
      .ack_i     (ack),
      .busy_o    (busy),
      .done_o    (done),
      .product_o (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full transaction: start at edge 0, result after edge 16, then ack.
   task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp);
      start  = 1'b1;
      mcand  = a;
      mplier = b;
      tick();
      start  = 1'b0;
      mcand  = 16'hDEAD;
      mplier = 16'hBEEF;
      check({tag, "_busy0"}, {31'd0, busy}, 32'd1);
      repeat (15) tick();
      check({tag, "_done15"}, {31'd0, done}, 32'd0);
      tick();
      check({tag, "_done16"}, {31'd0, done}, 32'd1);
      check({tag, "_prod"}, product, exp);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check({tag, "_ackdone"}, {31'd0, done}, 32'd0);
      check({tag, "_ackbusy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic [31:0] held;
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      start  = 1'b0;
      mcand  = 16'd0;
      mplier = 16'd0;
      ack    = 1'b0;
      #12;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_prod", product, 32'd0);
      rst_n = 1'b1;
      tick();

      // ack while idle does nothing
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("idle_ack", {31'd0, busy}, 32'd0);

      run_mul("m3x5", 16'd3, 16'd5, 32'h0000000F);
      run_mul("mminsq", 16'h8000, 16'h8000, 32'h40000000);
      run_mul("mneg1", 16'hFFFF, 16'h7FFF, 32'hFFFF8001);
      run_mul("mmaxsq", 16'h7FFF, 16'h7FFF, 32'h3FFF0001);
      run_mul("mzero", 16'h0000, 16'hFFFB, 32'h00000000);

      // start re-pulsed mid-iteration must be ignored
      start  = 1'b1;
      mcand  = 16'd2;
      mplier = 16'd3;
      tick();
      start = 1'b0;
      repeat (4) tick();
      start  = 1'b1;
      mcand  = 16'd7;
      mplier = 16'd7;
      tick();
      start = 1'b0;
      repeat (10) tick();
      check("restart_done15", {31'd0, done}, 32'd0);
      tick();
      check("restart_done16", {31'd0, done}, 32'd1);
      check("restart_prod", product, 32'd6);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("restart_idle", {31'd0, busy}, 32'd0);
      repeat (20) tick();
      check("restart_nobusy", {31'd0, busy}, 32'd0);
      check("restart_nodone", {31'd0, done}, 32'd0);
      check("restart_hold", product, 32'd6);

      // DONE holds with no ack while start and operands toggle
      start  = 1'b1;
      mcand  = 16'hFFFD;
      mplier = 16'd4;
      tick();
      start = 1'b0;
      repeat (16) tick();
      check("hold_prod0", product, 32'hFFFFFFF4);
      held = product;
      for (int i = 0; i < 10; i++) begin
         start  = ~start;
         mcand  = mcand + 16'd17;
         mplier = mplier ^ 16'h5A5A;
         tick();
         check("hold_done", {31'd0, done}, 32'd1);
         check("hold_busy", {31'd0, busy}, 32'd1);
         check("hold_prod", product, held);
      end
      // start and ack together: back to idle only
      start = 1'b1;
      ack   = 1'b1;
      tick();
      start = 1'b0;
      ack   = 1'b0;
      check("startack_idle", {31'd0, busy}, 32'd0);
      tick();
      check("startack_noop", {31'd0, busy}, 32'd0);

      // asynchronous reset mid-operation
      start  = 1'b1;
      mcand  = 16'd100;
      mplier = 16'd100;
      tick();
      start = 1'b0;
      repeat (8) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_done", {31'd0, done}, 32'd0);
      check("arst_prod", product, 32'd0);
      #3;
      rst_n = 1'b1;
      tick();
      check("arst_idle", {31'd0, busy}, 32'd0);
      run_mul("m100", 16'd100, 16'd100, 32'd10000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
